stage_loader: RTL
=================

STAGE_LOADER -- requirements
Module: stage_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: width of the database address.
REQ-002 The block SHALL have parameter DATA_WIDTH_16, default 16: width of one database word.
REQ-003 The block SHALL have parameter NUM_DATABASE_INDEX, default 10: number of words per stage.
REQ-004 The block SHALL have parameter NUM_FIELDS, default 5: words per feature record; NUM_DATABASE_INDEX SHALL be a multiple of NUM_FIELDS.
REQ-005 The block SHALL have parameter FEAT_WIDTH, default 8: width of the feature counter.
REQ-006 The block SHALL have port clk_fpga, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port reset_fpga, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_start, input, 1 bit: start-of-load pulse.
REQ-009 The block SHALL have port i_data, input, DATA_WIDTH_16 bits: database word, valid one cycle after o_ren_database.
REQ-010 The block SHALL have port i_address, input, ADDR_WIDTH bits: the database's current index.
REQ-011 The block SHALL have port i_end_count, input, 1 bit: database index counter at its maximum.
REQ-012 The block SHALL have port o_ren_database, output, 1 bit: database read enable.
REQ-013 The block SHALL have port o_ren_database_index, output, 1 bit: database index-advance enable.
REQ-014 The block SHALL have port o_feature, output, NUM_FIELDS*DATA_WIDTH_16 bits: packed feature record; field k is at bits [16k+15:16k].
REQ-015 The block SHALL have port o_feature_valid, output, 1 bit: o_feature is valid.
REQ-016 The block SHALL have port i_feature_ready, input, 1 bit: downstream accepts the feature.
REQ-017 The block SHALL have port o_feature_index, output, FEAT_WIDTH bits: index of the presented feature.
REQ-018 The block SHALL have port o_busy, output, 1 bit: high while the FSM is not IDLE.
REQ-019 The block SHALL have port o_done, output, 1 bit: one-cycle pulse at end of stage.
REQ-020 The block SHALL have port o_error, output, 1 bit: sticky address-mismatch flag.

Function
REQ-021 The FSM SHALL have the states IDLE, READ, CAPTURE, EMIT and DONE, all registered.
REQ-022 In IDLE, i_start=1 SHALL clear o_error, word_cnt, field_cnt and o_feature_index, then go to READ; i_start SHALL be ignored in all other states.
REQ-023 In READ, o_ren_database=1 for exactly one cycle; next state is CAPTURE.
REQ-024 In CAPTURE, the block SHALL latch i_data into field slot field_cnt and pulse o_ren_database_index=1 for one cycle.
REQ-025 In CAPTURE, the block SHALL increment word_cnt, and SHALL increment field_cnt modulo NUM_FIELDS.
REQ-026 In CAPTURE, if i_address != word_cnt, o_error SHALL be set and remain set until the next accepted i_start; loading SHALL continue.
REQ-027 From CAPTURE, the next state SHALL be EMIT if field_cnt == NUM_FIELDS-1, otherwise READ.
REQ-028 Word throughput SHALL be 2 cycles per word with no backpressure.
REQ-029 In EMIT, o_feature_valid=1, with o_feature and o_feature_index held stable, until the cycle in which i_feature_ready=1.
REQ-030 On the EMIT handshake, o_feature_valid SHALL drop the next cycle and o_feature_index SHALL increment; next state is DONE if word_cnt == NUM_DATABASE_INDEX, otherwise READ.
REQ-031 i_feature_ready=1 in the same cycle EMIT is entered SHALL complete the handshake in that single cycle.
REQ-032 If i_end_count=1 during CAPTURE while word_cnt != NUM_DATABASE_INDEX-1, o_error SHALL be set.
REQ-033 The index advance on the final word SHALL wrap the database counter to 0, so a following i_start rereads from address 0.
REQ-034 DONE SHALL pulse o_done=1 for one cycle and then go to IDLE.
REQ-035 o_busy SHALL be 0 only in IDLE.
REQ-036 o_ren_database and o_ren_database_index SHALL never be high in the same cycle, and SHALL never be high in IDLE, EMIT or DONE.

Reset
REQ-037 reset_fpga=0 SHALL immediately, without waiting for a clock edge, force state=IDLE and clear all counters, o_feature, o_feature_index, o_feature_valid, o_ren_database, o_ren_database_index, o_busy, o_done and o_error.
REQ-038 Reset mid-load SHALL discard the partial feature; a new i_start after reset SHALL restart from word_cnt=0.
REQ-039 Release of reset_fpga SHALL take effect at the next rising edge of clk_fpga, with the FSM in IDLE.

Verification
REQ-040 Nominal load: database words 1..10, NUM_FIELDS=5, ready tied high, i_start pulse -> feature 0 = {5,4,3,2,1} with index 0, then feature 1 = {10,9,8,7,6} with index 1, o_done pulse at cycle 23 after start, o_error=0.
REQ-041 Backpressure: i_feature_ready low for 7 cycles at EMIT -> o_feature_valid and o_feature held stable for 8 cycles, no reads occur meanwhile, and the data is unchanged.
REQ-042 Address skew: i_address stuck at 3 -> o_error rises at the first CAPTURE, both features are still emitted, and the next i_start clears o_error.
REQ-043 Reset mid-load: assert reset during the CAPTURE of word 7 -> all outputs are 0 asynchronously; after release and i_start, feature 0 again = {5,4,3,2,1}.
REQ-044 Start while busy: i_start pulsed during READ and EMIT -> no effect; counters and outputs are identical to REQ-040.
REQ-045 Back-to-back stages: a second i_start one cycle after o_done -> the first read is at i_address 0 and the output is identical to REQ-040.

Source files
------------

// File: rtl/stage_loader.sv
// Stage loader: reads NUM_DATABASE_INDEX words from the feature database,
// packs them into NUM_FIELDS-word records and hands each record downstream.
module stage_loader #(
  parameter int ADDR_WIDTH         = 10,
  parameter int DATA_WIDTH_16      = 16,
  parameter int NUM_DATABASE_INDEX = 10,
  parameter int NUM_FIELDS         = 5,
  parameter int FEAT_WIDTH         = 8
) (
  input  logic                                clk_fpga,
  input  logic                                reset_fpga,
  input  logic                                i_start,
  input  logic [DATA_WIDTH_16-1:0]            i_data,
  input  logic [ADDR_WIDTH-1:0]               i_address,
  input  logic                                i_end_count,
  output logic                                o_ren_database,
  output logic                                o_ren_database_index,
  output logic [NUM_FIELDS*DATA_WIDTH_16-1:0] o_feature,
  output logic                                o_feature_valid,
  input  logic                                i_feature_ready,
  output logic [FEAT_WIDTH-1:0]               o_feature_index,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_error
);

  localparam int WORD_CNT_W  = $clog2(NUM_DATABASE_INDEX + 1);
  localparam int FIELD_CNT_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  localparam logic [WORD_CNT_W-1:0]  LAST_WORD  = WORD_CNT_W'(NUM_DATABASE_INDEX - 1);
  localparam logic [WORD_CNT_W-1:0]  ALL_WORDS  = WORD_CNT_W'(NUM_DATABASE_INDEX);
  localparam logic [FIELD_CNT_W-1:0] LAST_FIELD = FIELD_CNT_W'(NUM_FIELDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [WORD_CNT_W-1:0]   word_cnt;
  logic [FIELD_CNT_W-1:0]  field_cnt;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    addr_mismatch;
  logic                    early_end;
  logic                    handshake;
  logic                    start_accept;

  assign word_addr     = ADDR_WIDTH'(word_cnt);
  assign addr_mismatch = (i_address != word_addr);
  assign early_end     = i_end_count && (word_cnt != LAST_WORD);
  assign handshake     = (state == EMIT) && i_feature_ready;
  assign start_accept  = (state == IDLE) && i_start;

  // Strobes are decoded from the registered state, so reset clears them at once.
  assign o_ren_database       = (state == READ);
  assign o_ren_database_index = (state == CAPTURE);
  assign o_feature_valid      = (state == EMIT);
  assign o_busy               = (state != IDLE);
  assign o_done               = (state == DONE);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = (field_cnt == LAST_FIELD) ? EMIT : READ;
      EMIT: begin
        if (i_feature_ready) begin
          state_nxt = (word_cnt == ALL_WORDS) ? DONE : READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: o_feature is a small flop bank, not a RAM, so it takes the async reset.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      word_cnt        <= '0;
      field_cnt       <= '0;
      o_feature       <= '0;
      o_feature_index <= '0;
      o_error         <= 1'b0;
    end else begin
      if (start_accept) begin
        word_cnt        <= '0;
        field_cnt       <= '0;
        o_feature_index <= '0;
        o_error         <= 1'b0;
      end

      if (state == CAPTURE) begin
        for (int k = 0; k < NUM_FIELDS; k++) begin
          if (field_cnt == FIELD_CNT_W'(k)) begin
            o_feature[k*DATA_WIDTH_16 +: DATA_WIDTH_16] <= i_data;
          end
        end
        word_cnt  <= word_cnt + WORD_CNT_W'(1);
        field_cnt <= (field_cnt == LAST_FIELD) ? '0 : field_cnt + FIELD_CNT_W'(1);
        // A skewed or prematurely ending database is flagged but the load carries on.
        if (addr_mismatch || early_end) begin
          o_error <= 1'b1;
        end
      end

      if (handshake) begin
        o_feature_index <= o_feature_index + FEAT_WIDTH'(1);
      end
    end
  end

endmodule
